// File: rtl/mem_pipe_n_pkg.sv
// Shared defaults and small types for the parametrised memory pipeline.
package mem_pipe_n_pkg;

    localparam int unsigned DEF_WORD_LEN     = 32;
    localparam int unsigned DEF_REG_ADDR_LEN = 5;
    localparam int unsigned DEF_BASE_ADDR    = 1024;
    localparam int unsigned MAX_MEM_STAGES   = 4;

    // Source of the value written back to the register file.
    typedef enum logic {
        WbSelAlu,
        WbSelMem
    } wb_sel_e;

endpackage

// File: rtl/mem_pipe_n_if.sv
// EXE-to-MEM inputs plus per-stage hazard/forwarding and WB outputs of the memory pipeline.
interface mem_pipe_n_if #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned MEM_STAGES   = 2
);
    logic                               stall;
    logic                               in_valid;
    logic                               in_wb_en;
    logic                               in_mem_r_en;
    logic                               in_mem_w_en;
    logic [WORD_LEN-1:0]                in_alu_res;
    logic [WORD_LEN-1:0]                in_st_val;
    logic [REG_ADDR_LEN-1:0]            in_dest;

    logic [MEM_STAGES*REG_ADDR_LEN-1:0] stg_dest;
    logic [MEM_STAGES-1:0]              stg_wb_en;
    logic [MEM_STAGES-1:0]              stg_load;
    logic [MEM_STAGES*WORD_LEN-1:0]     stg_alu;
    logic                               wb_en;
    logic [REG_ADDR_LEN-1:0]            wb_dest;
    logic [WORD_LEN-1:0]                wb_result;
    logic                               addr_err;

    modport master (
        output stall, in_valid, in_wb_en, in_mem_r_en, in_mem_w_en,
               in_alu_res, in_st_val, in_dest,
        input  stg_dest, stg_wb_en, stg_load, stg_alu,
               wb_en, wb_dest, wb_result, addr_err
    );

    modport slave (
        input  stall, in_valid, in_wb_en, in_mem_r_en, in_mem_w_en,
               in_alu_res, in_st_val, in_dest,
        output stg_dest, stg_wb_en, stg_load, stg_alu,
               wb_en, wb_dest, wb_result, addr_err
    );
endinterface

// File: rtl/mem_pipe_stage_reg.sv
// One memory-pipeline stage register: holds on stall, clears on async reset.
module mem_pipe_stage_reg #(
    parameter int unsigned WORD_LEN     = 32,
    parameter int unsigned REG_ADDR_LEN = 5,
    parameter int unsigned IDX_W        = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall_i,
    input  logic                    valid_i,
    input  logic                    wb_en_i,
    input  logic                    mem_r_en_i,
    input  logic                    mem_w_en_i,
    input  logic [REG_ADDR_LEN-1:0] dest_i,
    input  logic [WORD_LEN-1:0]     alu_res_i,
    input  logic [WORD_LEN-1:0]     st_val_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic                    in_range_i,
    output logic                    valid_o,
    output logic                    wb_en_o,
    output logic                    mem_r_en_o,
    output logic                    mem_w_en_o,
    output logic [REG_ADDR_LEN-1:0] dest_o,
    output logic [WORD_LEN-1:0]     alu_res_o,
    output logic [WORD_LEN-1:0]     st_val_o,
    output logic [IDX_W-1:0]        idx_o,
    output logic                    in_range_o
);
    logic                    valid_q, valid_d;
    logic                    wb_en_q, wb_en_d;
    logic                    mem_r_en_q, mem_r_en_d;
    logic                    mem_w_en_q, mem_w_en_d;
    logic [REG_ADDR_LEN-1:0] dest_q, dest_d;
    logic [WORD_LEN-1:0]     alu_res_q, alu_res_d;
    logic [WORD_LEN-1:0]     st_val_q, st_val_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    in_range_q, in_range_d;

    // Next state: capture the upstream slot unless stalled.
    always_comb begin
        valid_d    = valid_q;
        wb_en_d    = wb_en_q;
        mem_r_en_d = mem_r_en_q;
        mem_w_en_d = mem_w_en_q;
        dest_d     = dest_q;
        alu_res_d  = alu_res_q;
        st_val_d   = st_val_q;
        idx_d      = idx_q;
        in_range_d = in_range_q;
        if (!stall_i) begin
            valid_d    = valid_i;
            wb_en_d    = wb_en_i;
            mem_r_en_d = mem_r_en_i;
            mem_w_en_d = mem_w_en_i;
            dest_d     = dest_i;
            alu_res_d  = alu_res_i;
            st_val_d   = st_val_i;
            idx_d      = idx_i;
            in_range_d = in_range_i;
        end
    end

    // Stage state with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
            dest_q     <= '0;
            alu_res_q  <= '0;
            st_val_q   <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            wb_en_q    <= wb_en_d;
            mem_r_en_q <= mem_r_en_d;
            mem_w_en_q <= mem_w_en_d;
            dest_q     <= dest_d;
            alu_res_q  <= alu_res_d;
            st_val_q   <= st_val_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
        end
    end

    assign valid_o    = valid_q;
    assign wb_en_o    = wb_en_q;
    assign mem_r_en_o = mem_r_en_q;
    assign mem_w_en_o = mem_w_en_q;
    assign dest_o     = dest_q;
    assign alu_res_o  = alu_res_q;
    assign st_val_o   = st_val_q;
    assign idx_o      = idx_q;
    assign in_range_o = in_range_q;
endmodule

// File: rtl/mem_pipe_n.sv
// MEM_STAGES-deep memory pipeline with the data-memory access in the last stage
// and a registered MEM-to-WB boundary.
module mem_pipe_n
    import mem_pipe_n_pkg::*;
#(
    parameter int unsigned WORD_LEN     = DEF_WORD_LEN,
    parameter int unsigned REG_ADDR_LEN = DEF_REG_ADDR_LEN,
    parameter int unsigned MEM_STAGES   = 2,
    parameter int unsigned MEM_DEPTH    = 64,
    parameter int unsigned BASE_ADDR    = DEF_BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    mem_pipe_n_if.slave bus
);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned LAST  = MEM_STAGES - 1;
    localparam logic [WORD_LEN-1:0] BASE_W  = WORD_LEN'(BASE_ADDR);
    localparam logic [WORD_LEN-1:0] DEPTH_W = WORD_LEN'(MEM_DEPTH);

    // Word index and range check, computed once and carried with the instruction.
    logic [WORD_LEN-1:0] word_off;
    logic [IDX_W-1:0]    in_idx;
    logic                in_in_range;

    // Stage-1 address decode; byte-offset bits [1:0] are dropped by the shift.
    always_comb begin
        word_off    = (bus.in_alu_res - BASE_W) >> 2;
        in_in_range = (bus.in_alu_res >= BASE_W) && (word_off < DEPTH_W);
        in_idx      = word_off[IDX_W-1:0];
    end

    logic                    s_valid    [MEM_STAGES];
    logic                    s_wb_en    [MEM_STAGES];
    logic                    s_r_en     [MEM_STAGES];
    logic                    s_w_en     [MEM_STAGES];
    logic [REG_ADDR_LEN-1:0] s_dest     [MEM_STAGES];
    logic [WORD_LEN-1:0]     s_alu      [MEM_STAGES];
    logic [WORD_LEN-1:0]     s_st       [MEM_STAGES];
    logic [IDX_W-1:0]        s_idx      [MEM_STAGES];
    logic                    s_in_range [MEM_STAGES];

    for (genvar k = 0; k < MEM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Bubbles have all enables forced low so they cause no side effects.
            mem_pipe_stage_reg #(
                .WORD_LEN     (WORD_LEN),
                .REG_ADDR_LEN (REG_ADDR_LEN),
                .IDX_W        (IDX_W)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .stall_i    (bus.stall),
                .valid_i    (bus.in_valid),
                .wb_en_i    (bus.in_valid & bus.in_wb_en),
                .mem_r_en_i (bus.in_valid & bus.in_mem_r_en),
                .mem_w_en_i (bus.in_valid & bus.in_mem_w_en),
                .dest_i     (bus.in_dest),
                .alu_res_i  (bus.in_alu_res),
                .st_val_i   (bus.in_st_val),
                .idx_i      (in_idx),
                .in_range_i (in_in_range),
                .valid_o    (s_valid[k]),
                .wb_en_o    (s_wb_en[k]),
                .mem_r_en_o (s_r_en[k]),
                .mem_w_en_o (s_w_en[k]),
                .dest_o     (s_dest[k]),
                .alu_res_o  (s_alu[k]),
                .st_val_o   (s_st[k]),
                .idx_o      (s_idx[k]),
                .in_range_o (s_in_range[k])
            );
        end else begin : g_next
            mem_pipe_stage_reg #(
                .WORD_LEN     (WORD_LEN),
                .REG_ADDR_LEN (REG_ADDR_LEN),
                .IDX_W        (IDX_W)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .stall_i    (bus.stall),
                .valid_i    (s_valid[k-1]),
                .wb_en_i    (s_wb_en[k-1]),
                .mem_r_en_i (s_r_en[k-1]),
                .mem_w_en_i (s_w_en[k-1]),
                .dest_i     (s_dest[k-1]),
                .alu_res_i  (s_alu[k-1]),
                .st_val_i   (s_st[k-1]),
                .idx_i      (s_idx[k-1]),
                .in_range_i (s_in_range[k-1]),
                .valid_o    (s_valid[k]),
                .wb_en_o    (s_wb_en[k]),
                .mem_r_en_o (s_r_en[k]),
                .mem_w_en_o (s_w_en[k]),
                .dest_o     (s_dest[k]),
                .alu_res_o  (s_alu[k]),
                .st_val_o   (s_st[k]),
                .idx_o      (s_idx[k]),
                .in_range_o (s_in_range[k])
            );
        end

        assign bus.stg_dest[k*REG_ADDR_LEN +: REG_ADDR_LEN] = s_dest[k];
        assign bus.stg_alu[k*WORD_LEN +: WORD_LEN]          = s_alu[k];
        assign bus.stg_wb_en[k]                             = s_wb_en[k];
        assign bus.stg_load[k]                              = s_r_en[k];
    end

    logic [WORD_LEN-1:0]     mem_q [MEM_DEPTH];
    logic [WORD_LEN-1:0]     mem_d [MEM_DEPTH];
    logic                    wb_en_q, wb_en_d;
    logic [REG_ADDR_LEN-1:0] wb_dest_q, wb_dest_d;
    logic [WORD_LEN-1:0]     wb_result_q, wb_result_d;
    logic                    addr_err_q, addr_err_d;

    logic                    mem_op;
    logic                    mem_wr;
    logic                    acc_err;
    logic [WORD_LEN-1:0]     rdata;
    wb_sel_e                 wb_sel;

    // Last-stage access decode and combinational read; out-of-range loads read zero.
    always_comb begin
        mem_op  = s_valid[LAST] & (s_r_en[LAST] | s_w_en[LAST]);
        mem_wr  = s_valid[LAST] & s_w_en[LAST] & s_in_range[LAST];
        acc_err = mem_op & ~s_in_range[LAST];
        rdata   = s_in_range[LAST] ? mem_q[s_idx[LAST]] : '0;
        wb_sel  = s_r_en[LAST] ? WbSelMem : WbSelAlu;
    end

    // Next state for the WB register, the sticky error flag and the memory array.
    always_comb begin
        wb_en_d     = wb_en_q;
        wb_dest_d   = wb_dest_q;
        wb_result_d = wb_result_q;
        addr_err_d  = addr_err_q;
        mem_d       = mem_q;
        if (!bus.stall) begin
            wb_en_d     = s_wb_en[LAST];
            wb_dest_d   = s_dest[LAST];
            wb_result_d = (wb_sel == WbSelMem) ? rdata : s_alu[LAST];
            addr_err_d  = addr_err_q | acc_err;
            if (mem_wr) begin
                mem_d[s_idx[LAST]] = s_st[LAST];
            end
        end
    end

    // WB boundary, error flag and data memory, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q     <= 1'b0;
            wb_dest_q   <= '0;
            wb_result_q <= '0;
            addr_err_q  <= 1'b0;
            mem_q       <= '{default: '0};
        end else begin
            wb_en_q     <= wb_en_d;
            wb_dest_q   <= wb_dest_d;
            wb_result_q <= wb_result_d;
            addr_err_q  <= addr_err_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.wb_en     = wb_en_q;
    assign bus.wb_dest   = wb_dest_q;
    assign bus.wb_result = wb_result_q;
    assign bus.addr_err  = addr_err_q;
endmodule

// File: doc/mem_pipe_n.md
Name: mem_pipe_n

Overview:
- Parametrised successor to the fixed two-stage MEM1/MEM2 split.
- Carries EXE-stage results through MEM_STAGES memory pipeline stages and performs the data-memory access in the last stage.
- Registers the result into the MEM-to-WB boundary and produces the WB mux value.
- Exports per-stage destination, write-enable and load flags plus ALU values, so hazard and forwarding logic can scale with pipeline depth.

Parameters:
- WORD_LEN, 32, datapath width.
- REG_ADDR_LEN, 5, register-file address width.
- MEM_STAGES, 2, number of memory pipeline stages (1..4).
- MEM_DEPTH, 64, data memory size in words.
- BASE_ADDR, 1024, byte address mapped to word 0.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze all stage registers, the WB register and memory writes
- in_valid  in  1  EXE-stage slot holds a real instruction
- in_wb_en  in  1  register write-back requested
- in_mem_r_en  in  1  load
- in_mem_w_en  in  1  store
- in_alu_res  in  WORD_LEN  ALU result, or byte address for load/store
- in_st_val  in  WORD_LEN  store data
- in_dest  in  REG_ADDR_LEN  destination register
- stg_dest  out  MEM_STAGES*REG_ADDR_LEN  per-stage dest; stage 1 in the LSBs
- stg_wb_en  out  MEM_STAGES  per-stage valid&wb_en
- stg_load  out  MEM_STAGES  per-stage valid&mem_r_en
- stg_alu  out  MEM_STAGES*WORD_LEN  per-stage ALU result, for forwarding
- wb_en  out  1  valid&wb_en in the WB register
- wb_dest  out  REG_ADDR_LEN  WB destination
- wb_result  out  WORD_LEN  memory data if load, else ALU result
- addr_err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (async) clears every stage and the WB register to zero. All outputs read 0 and addr_err=0. Memory contents are cleared to 0.
- Stage k+1 loads stage k each edge when stall=0. Stage 1 loads the in_* signals. The WB register loads the last stage.
- Latency from in_valid to wb_en is MEM_STAGES+1 edges.
- stall=1: every register holds its value and no memory write occurs. stg_* and wb_* outputs stay constant.
- Address computation is done in stage 1 and registered with the instruction: word index = (alu_res - BASE_ADDR) >> 2.
- In range means alu_res >= BASE_ADDR and index < MEM_DEPTH. Bits [1:0] are ignored.
- Memory access happens only in the last stage.
- Read: the last stage reads the memory combinationally, and the result is captured into WB on the edge.
- Write: the array is written on the edge where the last stage is valid with mem_w_en=1 and stall=0. Each store therefore writes exactly once.
- A load immediately behind a store to the same address sees the new value, because accesses happen in program order at a single point.
- Out-of-range access:
  - A store is dropped.
  - A load returns 0.
  - addr_err sets on that edge and remains set until reset.
- in_valid=0 produces a bubble: all enables are forced to 0 in stage 1 and there are no memory side effects.
- Out-of-range checking applies only to valid instructions with mem_r_en or mem_w_en set.
- For loads, stg_alu carries the address. Consumers must use stg_load to block forwarding until WB.
- Reset mid-operation drops all in-flight instructions. Any store not yet at the last-stage edge never reaches memory.

Decomposition:
- Shared package/defines: WORD_LEN, REG_ADDR_LEN and the BASE_ADDR default, same as the existing defines file.
- One natural sub-module: mem_pipe_stage_reg.
  - A single stage register with stall hold and async reset.
  - Holds valid, wb_en, mem_r_en, mem_w_en, dest, alu_res, st_val and the precomputed word index with an in-range bit.
  - Instantiated MEM_STAGES times through a generate loop.
- The memory array stays in the top of the block.

Test Plan:
- MEM_STAGES=2. Store 0xDEADBEEF to address 1028, then load from 1028 into r7 on the next cycle.
  - Load reaches WB 3 edges after issue.
  - wb_dest=7, wb_result=0xDEADBEEF.
- ALU op with alu_res=0x55 and dest=r3.
  - stg_wb_en[0]=1 and stg_dest slice 0 =3 one edge after issue.
  - Then slice 1.
  - wb_result=0x55 after 3 edges.
- Store to address 1024+4*MEM_DEPTH (=1280).
  - No memory change; addr_err=1 and stays set.
  - A following load from 1020 also returns 0, with addr_err still 1.
- Store issued, then stall held for 5 cycles while the store sits in the last stage.
  - Memory written exactly once after the stall releases.
  - Outputs are frozen during the stall.
- MEM_STAGES=4. Back-to-back loads from 1024, 1028, 1032 preloaded with 1, 2, 3.
  - wb_result sequence is 1, 2, 3 on consecutive edges, starting 5 edges after the first issue.
  - stg_load shows 1 in each stage as the loads pass through.
- Assert rst while two stores are in flight.
  - All outputs go to 0 immediately (async).
  - Memory reads back 0 at the previously targeted addresses after reset releases.
